gpr_mp: RTL
===========

# gpr_mp

Parametrised successor to the CPU general-purpose register file. Provides DEPTH = 2^ADDR_W registers of DATA_W bits. It has two combinational read ports with write-through bypass and two write ports with fixed priority. A per-register busy scoreboard lets the decode stage detect pending writebacks, and a sequential soft-clear engine zeroes the whole bank without a reset. It sits between decode (read and scoreboard set) and writeback (two write ports: ALU result and memory load).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W
- ZERO_REG, 1, when 1 register 0 is hardwired to zero: writes ignored, never busy
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rd_addr_0  in  ADDR_W  read port 0 address
- rd_data_0  out  DATA_W  read port 0 data (combinational)
- busy_0  out  1  scoreboard busy flag for rd_addr_0 (combinational)
- rd_addr_1  in  ADDR_W  read port 1 address
- rd_data_1  out  DATA_W  read port 1 data (combinational)
- busy_1  out  1  scoreboard busy flag for rd_addr_1 (combinational)
- we0_  in  1  write port 0 enable, active-low
- wr_addr_0  in  ADDR_W  write port 0 address
- wr_data_0  in  DATA_W  write port 0 data
- we1_  in  1  write port 1 enable, active-low; higher priority than port 0
- wr_addr_1  in  ADDR_W  write port 1 address
- wr_data_1  in  DATA_W  write port 1 data
- sb_set_  in  1  active-low; mark register sb_addr busy (producer issued)
- sb_addr  in  ADDR_W  scoreboard set address
- clr_req  in  1  single-cycle pulse; starts soft clear
- clr_busy  out  1  high while soft clear runs

## Operation
- Reset (asynchronous, while reset=1):
  - all registers 0; all busy bits 0
  - FSM in IDLE, clr_cnt 0, clr_busy 0
- Writes, on the rising clk edge in IDLE:
  - the enabled port writes its data to its address
  - both ports enabled to the same address: port 1 data stored
  - ZERO_REG=1 and address 0: write dropped
- Reads, in IDLE:
  - ZERO_REG=1 and address 0 → 0.
  - Otherwise, if we1_=0 and the address matches wr_addr_1 → wr_data_1.
  - Otherwise, if we0_=0 and the address matches wr_addr_0 → wr_data_0.
  - Otherwise → array contents.
- Scoreboard, per-register busy bit, updated on the clk edge in IDLE:
  - write from either port to address a → busy[a] cleared
  - sb_set_=0 → busy[sb_addr] set
  - set and clear on the same address in the same cycle: set wins (a new producer supersedes the completing one)
  - ZERO_REG=1: busy[0] held 0
- busy_n output:
  - equals busy[rd_addr_n], forced 0 when a write to rd_addr_n is enabled this cycle (consistent with the data bypass)
  - forced 0 for address 0 when ZERO_REG=1
- Soft-clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on clr_req=1; clr_cnt ← 0.
  - In CLEAR, each cycle: reg[clr_cnt] ← 0, busy[clr_cnt] ← 0, clr_cnt increments.
  - CLEAR → IDLE on the edge where clr_cnt = DEPTH-1 (counter wraps to 0).
  - While in CLEAR:
    - write ports and sb_set_ are ignored (writes are lost)
    - bypass is disabled: reads return array contents
    - busy_n reads the raw busy bits
    - clr_req is ignored
- Reset asserted mid-clear: immediate return to IDLE, with all state as in the reset bullet.

## Timing
- Read data and busy flags: zero-cycle (combinational from addresses, write ports and state).
- Write to array and busy clear: visible from the array one cycle after the enabling edge; visible through the bypass in the same cycle.
- sb_set_: busy visible on busy_n the cycle after the set edge.
- Soft clear: clr_req sampled at edge T.
  - clr_busy = 1 from T through T+DEPTH; it falls at edge T+DEPTH.
  - Writes are accepted again at edge T+DEPTH.
  - Total DEPTH cycles in CLEAR (32 for the defaults).
- clr_busy is registered (state == CLEAR); reset value 0.

## Test plan
- Reset, then drive we0_=0, wr_addr_0=5, wr_data_0=0x12345678 for one cycle.
  - During that cycle: rd_addr_0=5 returns 0x12345678 via bypass.
  - After that edge: it reads from the array.
  - rd_addr_1=5 matches.
- Dual-write collision: we0_=0, we1_=0 same cycle, both to address 7, data 0xAAAA0000 / 0x5555FFFF.
  - During the cycle: read returns 0x5555FFFF.
  - After the edge: read still returns 0x5555FFFF.
- Register 0 with ZERO_REG=1:
  - write 0xFFFFFFFF to address 0 → read 0
  - sb_set_ on address 0 → busy_0=0
- Scoreboard:
  - sb_set_ on address 3 → busy_0=1 next cycle with rd_addr_0=3.
  - Write to 3 → busy_0=0 in the same cycle (forced), and 0 thereafter.
  - sb_set_ and a write to 3 in the same cycle → busy_0=1 after the edge.
- Soft clear: fill registers 1..31 with nonzero values and set several busy bits, then pulse clr_req.
  - clr_busy is high for exactly 32 cycles.
  - A write issued mid-clear is lost.
  - Afterwards all reads return 0 and all busy flags are 0.
- Reset mid-clear: assert reset at clr_cnt=10.
  - clr_busy drops immediately.
  - All registers read 0.
  - A write issued after reset is released is accepted.

Source files
------------

// File: rtl/gpr_mp.sv
// Multi-ported general-purpose register file: two bypassed read ports, two prioritised
// write ports, a per-register busy scoreboard and a sequential soft-clear engine.
module gpr_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_0,
  output logic [DATA_W-1:0] rd_data_0,
  output logic              busy_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              busy_1,
  input  logic              we0_,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic              we1_,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic              sb_set_,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic [DEPTH-1:0]    busy_q, busy_d;

  logic                idle;
  logic                wr_en0, wr_en1, sb_en;
  logic [ADDR_W-1:0]   rd_addr [2];
  logic [DATA_W-1:0]   rd_data [2];
  logic                rd_busy [2];

  assign idle   = (state_q == IDLE);
  // Enables already exclude the hardwired zero register, so bypass and scoreboard need no extra check.
  assign wr_en0 = !we0_    && idle && !(ZERO_REG && (wr_addr_0 == '0));
  assign wr_en1 = !we1_    && idle && !(ZERO_REG && (wr_addr_1 == '0));
  assign sb_en  = !sb_set_ && idle && !(ZERO_REG && (sb_addr   == '0));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Port 1 is applied last so it wins an address collision.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (!idle) begin
      regs_d[clr_cnt_q] = '0;
      busy_d[clr_cnt_q] = 1'b0;
    end else begin
      if (wr_en0) begin
        regs_d[wr_addr_0] = wr_data_0;
        busy_d[wr_addr_0] = 1'b0;
      end
      if (wr_en1) begin
        regs_d[wr_addr_1] = wr_data_1;
        busy_d[wr_addr_1] = 1'b0;
      end
      if (sb_en) busy_d[sb_addr] = 1'b1;
    end
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      busy_q    <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rd_addr[0] = rd_addr_0;
  assign rd_addr[1] = rd_addr_1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if (wr_en1 && (wr_addr_1 == rd_addr[p])) begin
        rd_data[p] = wr_data_1;
        rd_busy[p] = 1'b0;
      end else if (wr_en0 && (wr_addr_0 == rd_addr[p])) begin
        rd_data[p] = wr_data_0;
        rd_busy[p] = 1'b0;
      end
      if (ZERO_REG && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign rd_data_0 = rd_data[0];
  assign rd_data_1 = rd_data[1];
  assign busy_0    = rd_busy[0];
  assign busy_1    = rd_busy[1];
  assign clr_busy  = (state_q == CLEAR);

endmodule
